// File: rtl/mem_scan_pkg.sv
// Shared encodings and sizing helpers for the memory scan display.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        ModeManual = 2'b00,
        ModeAuto   = 2'b01,
        ModeStep   = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StFetch   = 2'b01,
        StCapture = 2'b10
    } state_e;

    function automatic int unsigned calc_nseg(input int unsigned data_w,
                                              input int unsigned disp_w);
        return data_w / disp_w;
    endfunction

    function automatic int unsigned calc_seg_w(input int unsigned nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first at cycle DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mem_scan_display.sv
// Scans words of an external instruction memory and shows one DISP_W-bit
// segment of the captured word; manual, auto-scan, single-step and hold modes.
module mem_scan_display
    import mem_scan_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DISP_W   = 16,
    parameter int unsigned TICK_DIV = 100_000_000,
    localparam int unsigned NSEG    = calc_nseg(DATA_W, DISP_W),
    localparam int unsigned SEG_W   = calc_seg_w(NSEG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] man_addr,
    input  logic [SEG_W-1:0]  seg_sel,
    input  logic              step,
    output logic [31:0]       mem_pc,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DISP_W-1:0] disp,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [SEG_W-1:0]  LAST_SEG  = SEG_W'(NSEG - 1);
    localparam logic [SEG_W:0]    NSEG_V    = (SEG_W + 1)'(NSEG);

    function automatic logic [DISP_W-1:0] seg_slice(input logic [DATA_W-1:0] word,
                                                    input logic [SEG_W-1:0]  s);
        return DISP_W'(word >> (DISP_W * s));
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, tgt_q, tgt_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                valid_q, valid_d, pend_q, pend_d, wrap_q, wrap_d, step_q;
    logic                tick, event_now, ev;
    mode_e               mode_in;
    logic [SEG_W-1:0]    seg_sel_eff;
    logic [ADDR_W-1:0]   man_tgt;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign mode_in     = mode_e'(mode);
    assign seg_sel_eff = ({1'b0, seg_sel} < NSEG_V) ? seg_sel : '0;
    assign man_tgt     = ({1'b0, man_addr} < DEPTH_V) ? man_addr : '0;
    assign event_now   = (tick && (mode_in == ModeManual || mode_in == ModeAuto)) ||
                         (step && !step_q && mode_in == ModeStep);
    // A pending event is serviced exactly like a fresh one on return to idle.
    assign ev          = event_now || pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            tgt_q   <= '0;
            seg_q   <= '0;
            word_q  <= '0;
            disp_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            seg_q   <= seg_d;
            word_q  <= word_d;
            disp_q  <= disp_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            wrap_q  <= wrap_d;
            step_q  <= step;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        seg_d   = seg_q;
        word_d  = word_q;
        disp_d  = disp_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                pend_d = 1'b0;
                unique case (mode_in)
                    ModeManual: begin
                        seg_d  = seg_sel_eff;
                        disp_d = seg_slice(word_q, seg_sel_eff);
                        if (!valid_q) begin
                            tgt_d   = addr_q;
                            state_d = StFetch;
                        end else if (man_tgt != addr_q || ev) begin
                            tgt_d   = man_tgt;
                            state_d = StFetch;
                        end
                    end
                    ModeAuto, ModeStep: begin
                        if (!valid_q) begin
                            tgt_d   = addr_q;
                            state_d = StFetch;
                        end else if (ev) begin
                            if (seg_q >= LAST_SEG) begin
                                seg_d   = '0;
                                wrap_d  = (addr_q >= LAST_ADDR);
                                tgt_d   = (addr_q >= LAST_ADDR) ? '0 : addr_q + 1'b1;
                                state_d = StFetch;
                            end else begin
                                seg_d  = seg_q + 1'b1;
                                disp_d = seg_slice(word_q, seg_q + 1'b1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            StFetch: begin
                pend_d  = pend_q || event_now;
                state_d = StCapture;
            end
            StCapture: begin
                pend_d  = pend_q || event_now;
                word_d  = mem_rdata;
                disp_d  = seg_slice(mem_rdata, seg_q);
                valid_d = 1'b1;
                addr_d  = tgt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en = (state_q == StFetch);
        mem_pc = 32'({tgt_q, 2'b00});
    end

    assign disp       = disp_q;
    assign disp_valid = valid_q;
    assign cur_addr   = addr_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_mem_scan_display.sv
// Scoreboard bench: fetches are queued by the stimulus and checked by a monitor
// on every mem_en, including the displayed result two cycles later.
module tb_mem_scan_display;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DISP_W   = 16;
    localparam int unsigned TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic [ADDR_W-1:0] man_addr = 4'd3;
    logic [0:0]        seg_sel = 1'b0;
    logic              step = 1'b0;
    logic [31:0]       mem_pc;
    logic              mem_en;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DISP_W-1:0] disp;
    logic              disp_valid;
    logic [ADDR_W-1:0] cur_addr;
    logic              wrap;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] disp;
        logic [3:0]  addr;
        bit          chk;
    } exp_t;

    exp_t exp_q[$];
    bit   refresh_ok[16];
    bit   mon_busy = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   wrap_cnt = 0;
    int   fetch_cnt = 0;

    mem_scan_display #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .DISP_W   (DISP_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .man_addr   (man_addr),
        .seg_sel    (seg_sel),
        .step       (step),
        .mem_pc     (mem_pc),
        .mem_en     (mem_en),
        .mem_rdata  (mem_rdata),
        .disp       (disp),
        .disp_valid (disp_valid),
        .cur_addr   (cur_addr),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Memory word at a = {A000+a, 5000+a}, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem_rdata <= {16'hA000 + 16'(mem_pc[5:2]), 16'h5000 + 16'(mem_pc[5:2])};
        end
    end

    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_cnt++;
        if (mem_en === 1'b1) fetch_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic void push(input logic [3:0] a, input logic [15:0] d, input bit chk);
        exp_t e;
        e.pc   = 32'({a, 2'b00});
        e.disp = d;
        e.addr = a;
        e.chk  = chk;
        exp_q.push_back(e);
    endfunction

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout with %0d fetches outstanding, expected 0", name, exp_q.size());
        exp_q.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (exp_q.size() > 0 &&
                    (mem_pc === exp_q[0].pc || !refresh_ok[mem_pc[5:2]])) begin
                    e = exp_q.pop_front();
                    mon_busy = 1'b1;
                    check("fetch_pc", mem_pc, e.pc);
                    if (e.chk) begin
                        repeat (2) @(negedge clk);
                        check("fetch_disp", 32'(disp), 32'(e.disp));
                        check("fetch_cur_addr", 32'(cur_addr), 32'(e.addr));
                        check("fetch_disp_valid", 32'(disp_valid), 32'h1);
                    end
                    mon_busy = 1'b0;
                end else if (!refresh_ok[mem_pc[5:2]]) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: mem_pc %h, expected no fetch", mem_pc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit seen;

        // Reset values, then first fetch of 0 followed by manual address 3.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_disp", 32'(disp), 32'h0);
        check("rst_disp_valid", 32'(disp_valid), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_cur_addr", 32'(cur_addr), 32'h0);
        refresh_ok[3] = 1'b1;
        push(4'd0, 16'h5000, 1'b1);
        push(4'd3, 16'h5003, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain("manual_first", 30);
        check("manual_disp", 32'(disp), 32'h5003);

        // Align to a refresh, change seg_sel while idle: display follows next cycle.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (mem_en === 1'b1);
        end
        check("refresh_seen", 32'(seen), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 seg_sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("seg_sel_disp", 32'(disp), 32'hA003);
        @(posedge clk);
        fetch_cnt = 0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        check("refresh_rate", 32'(fetch_cnt), 32'd3);

        // Manual to address 15 segment 1, then auto-scan wraps to 0.
        #1;
        refresh_ok[15] = 1'b1;
        push(4'd15, 16'hA00F, 1'b1);
        man_addr = 4'd15;
        wait_drain("manual_15", 30);
        wrap_cnt = 0;
        push(4'd0, 16'h5000, 1'b1);
        mode = 2'b01;
        wait_drain("auto_wrap", 30);
        mode = 2'b11;
        for (int i = 0; i < 16; i++) refresh_ok[i] = 1'b0;
        check("auto_cur_addr", 32'(cur_addr), 32'h0);
        check("auto_wrap_cnt", 32'(wrap_cnt), 32'd1);

        // Hold: address churn and ticks must not fetch or move the display.
        @(posedge clk);
        fetch_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            #1 man_addr = 4'(i + 5);
            @(posedge clk);
        end
        #1;
        check("hold_fetches", 32'(fetch_cnt), 32'd0);
        check("hold_disp", 32'(disp), 32'h5000);
        check("hold_cur_addr", 32'(cur_addr), 32'h0);

        // Single-step: a long step pulse advances once.
        mode = 2'b10;
        @(posedge clk);
        #1 step = 1'b1;
        repeat (10) @(posedge clk);
        #1 step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("step_hold_disp", 32'(disp), 32'hA000);
        check("step_hold_addr", 32'(cur_addr), 32'h0);
        check("step_hold_fetches", 32'(fetch_cnt), 32'd0);
        push(4'd1, 16'h5001, 1'b1);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        wait_drain("step_addr1", 30);
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("step_seg1_disp", 32'(disp), 32'hA001);

        // Edge in idle starts fetch of 2; edge during capture pends one segment step.
        push(4'd2, 16'h5002, 1'b1);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        wait_drain("step_pending", 30);
        repeat (3) @(posedge clk);
        #1;
        check("step_pending_disp", 32'(disp), 32'hA002);
        check("step_pending_addr", 32'(cur_addr), 32'h2);

        // Reset during the fetch of address 7 discards it.
        refresh_ok[7] = 1'b1;
        push(4'd7, 16'h0, 1'b0);
        mode = 2'b00;
        seg_sel = 1'b0;
        man_addr = 4'd7;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_disp", 32'(disp), 32'h0);
        check("midrst_disp_valid", 32'(disp_valid), 32'h0);
        check("midrst_cur_addr", 32'(cur_addr), 32'h0);
        check("midrst_mem_en", 32'(mem_en), 32'h0);
        check("midrst_wrap", 32'(wrap), 32'h0);
        push(4'd0, 16'h5000, 1'b1);
        push(4'd7, 16'h5007, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rel_t0_mem_en", 32'(mem_en), 32'h0);
        @(negedge clk);
        check("rel_t1_mem_en", 32'(mem_en), 32'h1);
        repeat (2) @(negedge clk);
        check("rel_t3_disp", 32'(disp), 32'h5000);
        wait_drain("after_reset", 30);
        check("final_disp", 32'(disp), 32'h5007);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
